// File: rtl/e203_exu_wbck_dual_pkg.sv
// Shared width constants for the dual-port write-back arbiter.
package e203_exu_wbck_dual_pkg;

  localparam int unsigned E203_XLEN         = 32;
  localparam int unsigned E203_RFIDX_WIDTH  = 5;
  localparam int unsigned LFIFO_CNT_W       = 3;

endpackage

// File: rtl/e203_exu_wbck_lfifo.sv
// Long-pipe write-back FIFO: circular buffer, push of 1, pop of 0/1/2,
// exposing the head and head+1 entries.
module e203_exu_wbck_lfifo
  import e203_exu_wbck_dual_pkg::*;
#(
  parameter int unsigned XLEN    = E203_XLEN,
  parameter int unsigned RFIDX_W = E203_RFIDX_WIDTH,
  parameter int unsigned DEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [XLEN-1:0]        push_wdat,
  input  logic [RFIDX_W-1:0]     push_rdidx,
  input  logic [1:0]             pop_cnt,
  output logic                   head_vld,
  output logic [XLEN-1:0]        head_wdat,
  output logic [RFIDX_W-1:0]     head_rdidx,
  output logic                   head1_vld,
  output logic [XLEN-1:0]        head1_wdat,
  output logic [RFIDX_W-1:0]     head1_rdidx,
  output logic [LFIFO_CNT_W-1:0] cnt,
  output logic                   full
);

  localparam int unsigned PTR_W = (DEPTH > 2) ? 2 : 1;

  logic [PTR_W-1:0]       wptr_q, wptr_d, rptr_q, rptr_d, rptr1;
  logic [LFIFO_CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]        dat_q [DEPTH];
  logic [XLEN-1:0]        dat_d [DEPTH];
  logic [RFIDX_W-1:0]     idx_q [DEPTH];
  logic [RFIDX_W-1:0]     idx_d [DEPTH];

  // Wrap at DEPTH so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(p + 1'b1);
  endfunction

  always_comb begin
    dat_d  = dat_q;
    idx_d  = idx_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    rptr1  = ptr_inc(rptr_q);
    if (push) begin
      dat_d[wptr_q] = push_wdat;
      idx_d[wptr_q] = push_rdidx;
      wptr_d        = ptr_inc(wptr_q);
    end
    case (pop_cnt)
      2'd1:    rptr_d = rptr1;
      2'd2:    rptr_d = ptr_inc(rptr1);
      default: rptr_d = rptr_q;
    endcase
    cnt_d = LFIFO_CNT_W'(cnt_q + LFIFO_CNT_W'(push) - LFIFO_CNT_W'(pop_cnt));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      dat_q  <= '{default: '0};
      idx_q  <= '{default: '0};
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      dat_q  <= dat_d;
      idx_q  <= idx_d;
    end
  end

  assign head_vld    = (cnt_q != '0);
  assign head1_vld   = (cnt_q > LFIFO_CNT_W'(1));
  assign head_wdat   = dat_q[rptr_q];
  assign head_rdidx  = idx_q[rptr_q];
  assign head1_wdat  = dat_q[rptr1];
  assign head1_rdidx = idx_q[rptr1];
  assign cnt         = cnt_q;
  assign full        = (cnt_q == LFIFO_CNT_W'(DEPTH));

endmodule

// File: rtl/e203_exu_wbck_dual.sv
// Dual-port write-back arbiter: merges ALU lane 0/1 and the long-pipe FIFO
// into at most two registered register-file writes per cycle.
module e203_exu_wbck_dual
  import e203_exu_wbck_dual_pkg::*;
#(
  parameter int unsigned XLEN        = E203_XLEN,
  parameter int unsigned RFIDX_W     = E203_RFIDX_WIDTH,
  parameter int unsigned LFIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu0_wbck_i_valid,
  output logic               alu0_wbck_i_ready,
  input  logic [XLEN-1:0]    alu0_wbck_i_wdat,
  input  logic [RFIDX_W-1:0] alu0_wbck_i_rdidx,
  input  logic               alu1_wbck_i_valid,
  output logic               alu1_wbck_i_ready,
  input  logic [XLEN-1:0]    alu1_wbck_i_wdat,
  input  logic [RFIDX_W-1:0] alu1_wbck_i_rdidx,
  input  logic               longp_wbck_i_valid,
  output logic               longp_wbck_i_ready,
  input  logic [XLEN-1:0]    longp_wbck_i_wdat,
  input  logic [RFIDX_W-1:0] longp_wbck_i_rdidx,
  output logic               wbck_dest_wen1,
  output logic [RFIDX_W-1:0] wbck_dest_idx1,
  output logic [XLEN-1:0]    wbck_dest_dat1,
  output logic               wbck_dest_wen2,
  output logic [RFIDX_W-1:0] wbck_dest_idx2,
  output logic [XLEN-1:0]    wbck_dest_dat2,
  output logic [2:0]         lfifo_cnt,
  output logic               longp_pend
);

  logic                   fifo_push, fifo_full;
  logic [1:0]             fifo_pop;
  logic                   h0_vld, h1_vld;
  logic [XLEN-1:0]        h0_dat, h1_dat;
  logic [RFIDX_W-1:0]     h0_idx, h1_idx;
  logic [LFIFO_CNT_W-1:0] fifo_cnt;

  logic [3:0]         cand_vld, slot_gnt;
  logic [RFIDX_W-1:0] cand_idx [4];
  logic [XLEN-1:0]    cand_dat [4];
  logic [1:0]         n_gnt;
  logic               g_alu0, g_alu1, g_h0, g_h1;
  logic               p1_vld, p2_vld;
  logic [RFIDX_W-1:0] p1_idx, p2_idx;
  logic [XLEN-1:0]    p1_dat, p2_dat;

  logic               wen1_q, wen1_d, wen2_q, wen2_d;
  logic [RFIDX_W-1:0] idx1_q, idx1_d, idx2_q, idx2_d;
  logic [XLEN-1:0]    dat1_q, dat1_d, dat2_q, dat2_d;

  assign longp_wbck_i_ready = (fifo_cnt < LFIFO_CNT_W'(LFIFO_DEPTH));
  assign fifo_push          = longp_wbck_i_valid & longp_wbck_i_ready;

  e203_exu_wbck_lfifo #(
    .XLEN    (XLEN),
    .RFIDX_W (RFIDX_W),
    .DEPTH   (LFIFO_DEPTH)
  ) u_lfifo (
    .clk         (clk),
    .rst         (rst),
    .push        (fifo_push),
    .push_wdat   (longp_wbck_i_wdat),
    .push_rdidx  (longp_wbck_i_rdidx),
    .pop_cnt     (fifo_pop),
    .head_vld    (h0_vld),
    .head_wdat   (h0_dat),
    .head_rdidx  (h0_idx),
    .head1_vld   (h1_vld),
    .head1_wdat  (h1_dat),
    .head1_rdidx (h1_idx),
    .cnt         (fifo_cnt),
    .full        (fifo_full)
  );

  // Priority list; a full FIFO moves its head to the front to avoid starvation.
  always_comb begin
    cand_vld = '0;
    slot_gnt = '0;
    n_gnt    = 2'd0;
    p1_vld   = 1'b0;
    p1_idx   = '0;
    p1_dat   = '0;
    p2_vld   = 1'b0;
    p2_idx   = '0;
    p2_dat   = '0;
    for (int i = 0; i < 4; i++) begin
      cand_idx[i] = '0;
      cand_dat[i] = '0;
    end
    if (fifo_full) begin
      cand_vld[0] = h0_vld;            cand_idx[0] = h0_idx;            cand_dat[0] = h0_dat;
      cand_vld[1] = alu0_wbck_i_valid; cand_idx[1] = alu0_wbck_i_rdidx; cand_dat[1] = alu0_wbck_i_wdat;
      cand_vld[2] = alu1_wbck_i_valid; cand_idx[2] = alu1_wbck_i_rdidx; cand_dat[2] = alu1_wbck_i_wdat;
    end else begin
      cand_vld[0] = alu0_wbck_i_valid; cand_idx[0] = alu0_wbck_i_rdidx; cand_dat[0] = alu0_wbck_i_wdat;
      cand_vld[1] = alu1_wbck_i_valid; cand_idx[1] = alu1_wbck_i_rdidx; cand_dat[1] = alu1_wbck_i_wdat;
      cand_vld[2] = h0_vld;            cand_idx[2] = h0_idx;            cand_dat[2] = h0_dat;
    end
    cand_vld[3] = h1_vld;
    cand_idx[3] = h1_idx;
    cand_dat[3] = h1_dat;

    for (int i = 0; i < 4; i++) begin
      if (cand_vld[i] && (n_gnt < 2'd2)) begin
        slot_gnt[i] = 1'b1;
        if (n_gnt == 2'd0) begin
          p1_vld = 1'b1;
          p1_idx = cand_idx[i];
          p1_dat = cand_dat[i];
        end else begin
          p2_vld = 1'b1;
          p2_idx = cand_idx[i];
          p2_dat = cand_dat[i];
        end
        n_gnt = n_gnt + 2'd1;
      end
    end
  end

  assign g_alu0 = fifo_full ? slot_gnt[1] : slot_gnt[0];
  assign g_alu1 = fifo_full ? slot_gnt[2] : slot_gnt[1];
  assign g_h0   = fifo_full ? slot_gnt[0] : slot_gnt[2];
  assign g_h1   = slot_gnt[3];

  assign alu0_wbck_i_ready = g_alu0;
  assign alu1_wbck_i_ready = g_alu1;
  assign fifo_pop          = 2'(g_h0) + 2'(g_h1);

  // Same-index pair: the younger (port 2) write wins; x0 is never written.
  always_comb begin
    wen1_d = p1_vld && (p1_idx != '0) && !(p2_vld && (p2_idx == p1_idx));
    wen2_d = p2_vld && (p2_idx != '0);
    idx1_d = p1_idx;
    dat1_d = p1_dat;
    idx2_d = p2_idx;
    dat2_d = p2_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wen1_q <= 1'b0;
      idx1_q <= '0;
      dat1_q <= '0;
      wen2_q <= 1'b0;
      idx2_q <= '0;
      dat2_q <= '0;
    end else begin
      wen1_q <= wen1_d;
      idx1_q <= idx1_d;
      dat1_q <= dat1_d;
      wen2_q <= wen2_d;
      idx2_q <= idx2_d;
      dat2_q <= dat2_d;
    end
  end

  assign wbck_dest_wen1 = wen1_q;
  assign wbck_dest_idx1 = idx1_q;
  assign wbck_dest_dat1 = dat1_q;
  assign wbck_dest_wen2 = wen2_q;
  assign wbck_dest_idx2 = idx2_q;
  assign wbck_dest_dat2 = dat2_q;
  assign lfifo_cnt      = fifo_cnt;
  assign longp_pend     = (fifo_cnt != '0);

endmodule

// File: tb/tb_e203_exu_wbck_dual.sv
// Directed self-checking bench for the dual-port write-back arbiter.
module tb_e203_exu_wbck_dual;

  logic        clk = 1'b0;
  logic        rst;
  logic        a0_v, a0_r, a1_v, a1_r, lp_v, lp_r;
  logic [31:0] a0_d, a1_d, lp_d;
  logic [4:0]  a0_i, a1_i, lp_i;
  logic        wen1, wen2, pend;
  logic [4:0]  idx1, idx2;
  logic [31:0] dat1, dat2;
  logic [2:0]  cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  e203_exu_wbck_dual dut (
    .clk                (clk),
    .rst                (rst),
    .alu0_wbck_i_valid  (a0_v),
    .alu0_wbck_i_ready  (a0_r),
    .alu0_wbck_i_wdat   (a0_d),
    .alu0_wbck_i_rdidx  (a0_i),
    .alu1_wbck_i_valid  (a1_v),
    .alu1_wbck_i_ready  (a1_r),
    .alu1_wbck_i_wdat   (a1_d),
    .alu1_wbck_i_rdidx  (a1_i),
    .longp_wbck_i_valid (lp_v),
    .longp_wbck_i_ready (lp_r),
    .longp_wbck_i_wdat  (lp_d),
    .longp_wbck_i_rdidx (lp_i),
    .wbck_dest_wen1     (wen1),
    .wbck_dest_idx1     (idx1),
    .wbck_dest_dat1     (dat1),
    .wbck_dest_wen2     (wen2),
    .wbck_dest_idx2     (idx2),
    .wbck_dest_dat2     (dat2),
    .lfifo_cnt          (cnt),
    .longp_pend         (pend)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a0_v = 1'b0; a0_i = '0; a0_d = '0;
    a1_v = 1'b0; a1_i = '0; a1_d = '0;
    lp_v = 1'b0; lp_i = '0; lp_d = '0;
  endtask

  task automatic chk_port1(input string tag, input logic w, input logic [4:0] i, input logic [31:0] d);
    chk({tag, "_wen1"}, 32'(wen1), 32'(w));
    if (w) begin
      chk({tag, "_idx1"}, 32'(idx1), 32'(i));
      chk({tag, "_dat1"}, dat1, d);
    end
  endtask

  task automatic chk_port2(input string tag, input logic w, input logic [4:0] i, input logic [31:0] d);
    chk({tag, "_wen2"}, 32'(wen2), 32'(w));
    if (w) begin
      chk({tag, "_idx2"}, 32'(idx2), 32'(i));
      chk({tag, "_dat2"}, dat2, d);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_wen1"}, 32'(wen1), 0);
    chk({tag, "_idx1"}, 32'(idx1), 0);
    chk({tag, "_dat1"}, dat1, 0);
    chk({tag, "_wen2"}, 32'(wen2), 0);
    chk({tag, "_idx2"}, 32'(idx2), 0);
    chk({tag, "_dat2"}, dat2, 0);
    chk({tag, "_cnt"},  32'(cnt), 0);
    chk({tag, "_pend"}, 32'(pend), 0);
    chk({tag, "_lp_rdy"}, 32'(lp_r), 1);
  endtask

  initial begin
    int          k;
    int          nwr;
    int          exp_j;
    logic        acc;
    logic        seen;

    idle();
    rst = 1'b1;
    tick();
    tick();
    chk_reset_state("rst");
    rst = 1'b0;

    // Basic dual write
    a0_v = 1'b1; a0_i = 5'd5; a0_d = 32'h11;
    a1_v = 1'b1; a1_i = 5'd6; a1_d = 32'h22;
    #1;
    chk("dual_a0_rdy", 32'(a0_r), 1);
    chk("dual_a1_rdy", 32'(a1_r), 1);
    tick();
    chk_port1("dual", 1'b1, 5'd5, 32'h11);
    chk_port2("dual", 1'b1, 5'd6, 32'h22);

    // Same-index conflict: lane 1 wins
    a0_i = 5'd7; a0_d = 32'hAA;
    a1_i = 5'd7; a1_d = 32'hBB;
    #1;
    chk("conf_a0_rdy", 32'(a0_r), 1);
    chk("conf_a1_rdy", 32'(a1_r), 1);
    tick();
    chk_port1("conf", 1'b0, 5'd0, 32'h0);
    chk_port2("conf", 1'b1, 5'd7, 32'hBB);

    // x0 on both lanes: consumed, not written
    a0_i = 5'd0; a1_i = 5'd0;
    #1;
    chk("x0_a0_rdy", 32'(a0_r), 1);
    chk("x0_a1_rdy", 32'(a1_r), 1);
    tick();
    chk_port1("x0", 1'b0, 5'd0, 32'h0);
    chk_port2("x0", 1'b0, 5'd0, 32'h0);
    idle();

    // Long-pipe path latency
    lp_v = 1'b1; lp_i = 5'd9; lp_d = 32'h1234;
    #1;
    chk("lp_rdy", 32'(lp_r), 1);
    tick();
    idle();
    chk("lp_cnt_t1", 32'(cnt), 1);
    chk("lp_pend_t1", 32'(pend), 1);
    chk_port1("lp_t1", 1'b0, 5'd0, 32'h0);
    tick();
    chk_port1("lp_t2", 1'b1, 5'd9, 32'h1234);
    chk_port2("lp_t2", 1'b0, 5'd0, 32'h0);
    chk("lp_cnt_t2", 32'(cnt), 0);

    // Full priority: ALUs continuously valid
    a0_v = 1'b1; a0_i = 5'd1; a0_d = 32'hA0;
    a1_v = 1'b1; a1_i = 5'd2; a1_d = 32'hB0;
    lp_v = 1'b1; lp_i = 5'd10; lp_d = 32'hC1;
    tick();
    lp_i = 5'd11; lp_d = 32'hC2;
    #1;
    chk("fp_cnt1", 32'(cnt), 1);
    chk("fp_a1_rdy_nf", 32'(a1_r), 1);
    tick();
    lp_i = 5'd12; lp_d = 32'hC3;
    #1;
    chk("fp_cnt2", 32'(cnt), 2);
    chk("fp_lp_rdy_full", 32'(lp_r), 0);
    chk("fp_a0_rdy", 32'(a0_r), 1);
    chk("fp_a1_rdy", 32'(a1_r), 0);
    tick();
    chk_port1("fp_head", 1'b1, 5'd10, 32'hC1);
    chk_port2("fp_head", 1'b1, 5'd1, 32'hA0);
    chk("fp_cnt_after", 32'(cnt), 1);
    chk("fp_lp_rdy_drop", 32'(lp_r), 1);
    tick();
    lp_v = 1'b0;
    chk_port1("fp_alus", 1'b1, 5'd1, 32'hA0);
    chk_port2("fp_alus", 1'b1, 5'd2, 32'hB0);
    chk("fp_cnt_refill", 32'(cnt), 2);
    tick();
    a0_v = 1'b0; a1_v = 1'b0;
    chk_port1("fp_head2", 1'b1, 5'd11, 32'hC2);
    chk_port2("fp_head2", 1'b1, 5'd1, 32'hA0);
    tick();
    chk_port1("fp_drain", 1'b1, 5'd12, 32'hC3);
    chk_port2("fp_drain", 1'b0, 5'd0, 32'h0);
    chk("fp_cnt_empty", 32'(cnt), 0);
    idle();

    // Wrap-around: 10 pushes, ALUs alternating
    k = 0; nwr = 0; exp_j = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      a0_v = (cyc % 2 == 0); a0_i = 5'd3; a0_d = 32'h300 + 32'(cyc);
      a1_v = (cyc % 2 == 0); a1_i = 5'd4; a1_d = 32'h400 + 32'(cyc);
      lp_v = (k < 10);      lp_i = 5'(16 + k); lp_d = 32'h5000 + 32'(k);
      #1;
      acc = lp_v & lp_r;
      tick();
      if (acc) k++;
      if (wen1 && idx1 >= 5'd16) begin
        chk("wrap_idx_p1", 32'(idx1), 32'(16 + exp_j));
        chk("wrap_dat_p1", dat1, 32'h5000 + 32'(exp_j));
        exp_j++; nwr++;
      end
      if (wen2 && idx2 >= 5'd16) begin
        chk("wrap_idx_p2", 32'(idx2), 32'(16 + exp_j));
        chk("wrap_dat_p2", dat2, 32'h5000 + 32'(exp_j));
        exp_j++; nwr++;
      end
    end
    chk("wrap_pushes", 32'(k), 10);
    chk("wrap_writes", 32'(nwr), 10);
    chk("wrap_cnt_end", 32'(cnt), 0);
    idle();
    tick();

    // Reset mid-operation with a full FIFO
    a0_v = 1'b1; a0_i = 5'd1; a0_d = 32'h1;
    a1_v = 1'b1; a1_i = 5'd2; a1_d = 32'h2;
    lp_v = 1'b1; lp_i = 5'd20; lp_d = 32'hDEAD0;
    tick();
    lp_i = 5'd21; lp_d = 32'hDEAD1;
    tick();
    lp_v = 1'b0;
    #1;
    chk("mrst_cnt_full", 32'(cnt), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_state("mrst");
    idle();
    seen = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      tick();
      if ((wen1 && idx1 >= 5'd20) || (wen2 && idx2 >= 5'd20)) seen = 1'b1;
    end
    chk("mrst_no_stale_write", 32'(seen), 0);
    chk("mrst_cnt_end", 32'(cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/e203_exu_wbck_dual.md
# e203_exu_wbck_dual

Dual-port write-back arbiter feeding the two general-purpose register file write ports (`wbck_dest_*1`, `wbck_dest_*2`). It merges three result sources into at most two registered writes per cycle: ALU lane 0, ALU lane 1 and the long-pipeline result (LSU/MulDiv). Long-pipe results pass through a small FIFO. The block guarantees that the register file never sees two same-cycle writes to one index, and never sees a write to x0.

## Interface
Parameters:
- `XLEN`, default `E203_XLEN` (32): result data width.
- `RFIDX_W`, default `E203_RFIDX_WIDTH` (5): register index width.
- `LFIFO_DEPTH`, default 2: number of long-pipe FIFO entries (2..4).

Ports:
- `clk`  in  1  core clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `alu0_wbck_i_valid` / `alu0_wbck_i_ready`  in / out  1  ALU lane 0 handshake.
- `alu0_wbck_i_wdat`  in  XLEN  lane 0 result.
- `alu0_wbck_i_rdidx`  in  RFIDX_W  lane 0 destination.
- `alu1_wbck_i_valid` / `_ready` / `_wdat` / `_rdidx`: same fields for lane 1; lane 1 is program-order younger than lane 0.
- `longp_wbck_i_valid` / `_ready` / `_wdat` / `_rdidx`: same fields for the long-pipe result.
- `wbck_dest_wen1`  out  1  write port 1 enable.
- `wbck_dest_idx1`  out  RFIDX_W  write port 1 index.
- `wbck_dest_dat1`  out  XLEN  write port 1 data.
- `wbck_dest_wen2` / `wbck_dest_idx2` / `wbck_dest_dat2`: same fields for write port 2.
- `lfifo_cnt`  out  3  current long-pipe FIFO occupancy.
- `longp_pend`  out  1  FIFO non-empty; used by the commit stage for stall and flush decisions.

## Operation
- **Long-pipe FIFO.**
  - `longp_wbck_i_ready = (lfifo_cnt < LFIFO_DEPTH)`, taken from registered state only.
  - A push happens when valid and ready are both high.
  - A push and a pop in the same cycle leave the count unchanged.
- **Arbitration.** Each cycle, pick the first two valid candidates from a priority list.
  - Normal order: alu0, alu1, FIFO head, FIFO head+1.
  - When the FIFO is full (count == DEPTH) the order is: FIFO head, alu0, alu1, FIFO head+1. This prevents long-pipe starvation.
- **Grants.** The first grant drives port 1 and the second drives port 2.
  - `alu*_wbck_i_ready` equals that source's grant.
  - Granted FIFO entries are popped in order; a pop of 2 is allowed.
- **Same-index conflict.** If both grants target the same non-zero index, both are consumed but only the second is written (`wen1` = 0).
  - Upstream OITF guarantees that a long-pipe entry never shares an rd with an in-flight ALU result. A conflict can therefore only be alu0 vs alu1, and the younger lane 1 wins.
- **x0.** A grant with rdidx == 0 is consumed with its port's `wen` forced to 0, and it still occupies that port's slot.
- **Output registers.** `wen`/`idx`/`dat` are registered.
  - The `idx`/`dat` of a port with `wen` = 0 are don't-care, but must be 0 after reset.

## Timing
- **Reset.** The cycle after `rst` is sampled high:
  - `wbck_dest_wen1/2` = 0, `idx` = 0, `dat` = 0;
  - the FIFO is emptied, `lfifo_cnt` = 0, `longp_pend` = 0;
  - all `*_ready` outputs are driven from the reset state (`longp` ready = 1; ALU readys follow grants).
  - Reset mid-operation discards FIFO contents and any staged writes; nothing is written in the reset cycle or the cycle after.
- **ALU latency.** Accepted at edge T means `wen` is asserted during cycle T+1.
- **Long-pipe latency.** Pushed at T, eligible for grant at T+1, written at T+2 at the earliest. There is no bypass.
- **Throughput.** 2 writes per cycle sustained.
- **Starvation bound.** A FIFO-full condition guarantees one pop within 1 cycle.
- **Handshake rules.**
  - A `valid` not granted must stay asserted with stable data; the source holds it.
  - `ready` may depend combinationally on the same-cycle `valid` of higher-priority sources.
  - `longp` ready depends only on registered count.

## Structure
- `XLEN`, `RFIDX_W` and `RFREG_NUM` come from the shared `e203_defines.v` constants; no new typedefs.
- The arbitration priority list and the conflict/x0 masking live in the top module.
- One sub-module: `e203_exu_wbck_lfifo`.
  - Circular buffer, parameterised depth, with pointer wrap.
  - Push of 1 and pop of 0/1/2, exposing head and head+1 entries with their valids, plus count.

## Test plan
- **Basic dual write.** alu0 {idx 5, 0x11} and alu1 {idx 6, 0x22} valid at T.
  - Both ready at T.
  - At T+1: `wen1`=1 idx 5 dat 0x11, `wen2`=1 idx 6 dat 0x22.
- **Conflict and x0.**
  - alu0 {idx 7, 0xAA} and alu1 {idx 7, 0xBB} → both ready; at T+1 `wen1`=0, `wen2`=1 idx 7 dat 0xBB.
  - Repeat with idx 0 on both → both consumed, `wen1`=`wen2`=0.
- **Long-pipe path.** longp {idx 9, 0x1234} at T with ALUs idle.
  - `lfifo_cnt`=1 at T+1.
  - At T+2: `wen1`=1 idx 9 dat 0x1234, and `lfifo_cnt`=0.
- **Full priority.** Fill the FIFO to 2 while both ALUs are continuously valid.
  - The next cycle, the FIFO head takes port 1 and alu0 takes port 2.
  - alu1 ready=0 and holds; `longp` ready=0 until the count drops.
- **Wrap-around.** 10 back-to-back longp pushes with ALUs alternating valid.
  - All 10 write in push order with correct data.
  - Pointers wrap with no loss or duplication.
- **Reset mid-operation.** Assert `rst` for 1 cycle with the FIFO at count 2 and ALUs valid.
  - Next cycle: all outputs 0, `lfifo_cnt`=0, `longp` ready=1.
  - The discarded entries are never written.
